// File: rtl/mii_tx_scheduler_if.sv
// Requester/lane bundle for the MII TX scheduler.
// master = frame sources and lane observer, slave = scheduler.
interface mii_tx_scheduler_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]    i_req_valid;
  logic [N_REQ*64-1:0] i_req_data;
  logic [N_REQ-1:0]    i_req_last;
  logic [N_REQ*4-1:0]  i_req_bytes;
  logic [N_REQ-1:0]    o_req_ready;
  logic [63:0]         o_tx_data;
  logic [7:0]          o_tx_ctrl;
  logic [N_REQ-1:0]    o_grant;
  logic                o_len_err;
  logic                o_underrun;

  modport master (
    output i_req_valid, i_req_data,
    output i_req_last, i_req_bytes,
    input  o_req_ready, o_tx_data, o_tx_ctrl,
    input  o_grant, o_len_err, o_underrun
  );

  modport slave (
    input  i_req_valid, i_req_data,
    input  i_req_last, i_req_bytes,
    output o_req_ready, o_tx_data, o_tx_ctrl,
    output o_grant, o_len_err, o_underrun
  );
endinterface

// File: rtl/mii_tx_scheduler.sv
// Round-robin frame scheduler for one 64-bit/8-lane MII TX lane.
// Frames: START, data, TERM, then an enforced idle inter-frame gap.
module mii_tx_scheduler #(
  parameter int N_REQ       = 2,
  parameter int IFG_BYTES   = 12,
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500
) (
  input logic clk,
  input logic i_rst,
  mii_tx_scheduler_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [63:0] IDLE_W  = {8{8'h07}};
  localparam logic [63:0] START_W = 64'hD555555555555_5FB;
  localparam logic [63:0] TERM_W  = 64'h07070707070707FD;
  localparam logic [63:0] ERR_W   = {8{8'hFE}};

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_TERM, S_FLUSH, S_IFG
  } state_t;

  state_t           state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    owner;
  logic [5:0]       ifg_cnt;
  logic [10:0]      payload;
  logic [63:0]      tx_data;
  logic [7:0]       tx_ctrl;
  logic [N_REQ-1:0] ready;
  logic [N_REQ-1:0] grant;
  logic             len_err;
  logic             underrun;

  logic             found;
  logic [PW-1:0]    pick;
  logic [PW-1:0]    ptr_next;
  logic             launch;
  logic             cur_valid;
  logic             cur_last;
  logic [63:0]      cur_data;
  logic [3:0]       raw_k;
  logic [3:0]       cur_k;
  logic [63:0]      term_data;
  logic [7:0]       term_ctrl;
  logic [11:0]      pay_add8;
  logic [10:0]      pay_sat8;
  logic [11:0]      pay_last;
  logic             bad_last;
  logic             bad_term;
  logic [6:0]       ifg_add;
  logic [5:0]       ifg_sat;
  logic             ifg_ok;
  logic             ifg_next_ok;

  function automatic logic [N_REQ-1:0] onehot(
    input logic [PW-1:0] i
  );
    onehot = '0;
    onehot[i] = 1'b1;
  endfunction

  // first valid requester at or after the round-robin pointer
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found &&
          bus.i_req_valid[(int'(rr_ptr) + i) % N_REQ]) begin
        found = 1'b1;
        pick  = PW'((int'(rr_ptr) + i) % N_REQ);
      end
    end
    ptr_next = PW'((int'(pick) + 1) % N_REQ);
  end

  always_comb begin
    cur_valid = bus.i_req_valid[owner];
    cur_last  = bus.i_req_last[owner];
    cur_data  = bus.i_req_data[int'(owner)*64 +: 64];
    raw_k     = bus.i_req_bytes[int'(owner)*4 +: 4];
    cur_k     = (raw_k == 4'd0 || raw_k > 4'd8) ? 4'd8 : raw_k;
  end

  always_comb begin
    term_data = IDLE_W;
    term_ctrl = 8'hFF;
    for (int j = 0; j < 8; j++) begin
      if (4'(j) < cur_k) begin
        term_data[j*8 +: 8] = cur_data[j*8 +: 8];
        term_ctrl[j]        = 1'b0;
      end else if (4'(j) == cur_k) begin
        term_data[j*8 +: 8] = 8'hFD;
      end
    end
  end

  always_comb begin
    pay_add8 = {1'b0, payload} + 12'd8;
    pay_sat8 = pay_add8[11] ? 11'h7FF : pay_add8[10:0];
    pay_last = {1'b0, payload} + {8'b0, cur_k};
    bad_last = (pay_last < 12'(MIN_PAYLOAD)) ||
               (pay_last > 12'(MAX_PAYLOAD));
    bad_term = ({1'b0, payload} < 12'(MIN_PAYLOAD)) ||
               ({1'b0, payload} > 12'(MAX_PAYLOAD));
    ifg_add     = {1'b0, ifg_cnt} + 7'd8;
    ifg_sat     = ifg_add[6] ? 6'h3F : ifg_add[5:0];
    ifg_ok      = ifg_cnt >= 6'(IFG_BYTES);
    ifg_next_ok = ifg_sat >= 6'(IFG_BYTES);
    // a finishing gap may hand the lane straight to the next frame
    launch = found &&
             ((state == S_IDLE && ifg_ok) ||
              (state == S_IFG && ifg_next_ok));
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      ifg_cnt  <= 6'(IFG_BYTES);
      payload  <= '0;
      tx_data  <= IDLE_W;
      tx_ctrl  <= 8'hFF;
      ready    <= '0;
      grant    <= '0;
      len_err  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      len_err  <= 1'b0;
      underrun <= 1'b0;
      tx_data  <= IDLE_W;
      tx_ctrl  <= 8'hFF;
      unique case (state)
        S_IDLE: begin
        end
        S_START: begin
          tx_data <= START_W;
          tx_ctrl <= 8'h01;
          ready   <= onehot(owner);
          payload <= '0;
          state   <= S_DATA;
        end
        S_DATA: begin
          if (!cur_valid) begin
            tx_data  <= ERR_W;
            underrun <= 1'b1;
            ifg_cnt  <= '0;
            state    <= S_FLUSH;
          end else if (!cur_last) begin
            tx_data <= cur_data;
            tx_ctrl <= 8'h00;
            payload <= pay_sat8;
          end else if (cur_k == 4'd8) begin
            tx_data <= cur_data;
            tx_ctrl <= 8'h00;
            payload <= pay_sat8;
            ready   <= '0;
            state   <= S_TERM;
          end else begin
            tx_data <= term_data;
            tx_ctrl <= term_ctrl;
            len_err <= bad_last;
            ifg_cnt <= 6'd7 - {2'b0, cur_k};
            ready   <= '0;
            state   <= S_IFG;
          end
        end
        S_TERM: begin
          tx_data <= TERM_W;
          tx_ctrl <= 8'hFF;
          len_err <= bad_term;
          ifg_cnt <= 6'd7;
          state   <= S_IFG;
        end
        S_FLUSH: begin
          ifg_cnt <= ifg_sat;
          if (cur_valid && cur_last) begin
            ready <= '0;
            state <= S_IFG;
          end
        end
        S_IFG: begin
          ifg_cnt <= ifg_sat;
          if (ifg_next_ok) begin
            grant <= '0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (launch) begin
        owner  <= pick;
        grant  <= onehot(pick);
        rr_ptr <= ptr_next;
        state  <= S_START;
      end
    end
  end

  assign bus.o_req_ready = ready;
  assign bus.o_tx_data   = tx_data;
  assign bus.o_tx_ctrl   = tx_ctrl;
  assign bus.o_grant     = grant;
  assign bus.o_len_err   = len_err;
  assign bus.o_underrun  = underrun;
endmodule
